// File: rtl/systemverilog_str2bus_pkg.sv
// Shared widths and types for the byte-stream to bus-write deserializer.
// The flush feature (STR2BUS_FLUSH_EN) needs no package content.
package systemverilog_str2bus_pkg;

    // Stream side
    localparam int STR_BW = 8;
    typedef logic [STR_BW-1:0] str_byte_t;

    // Bus side
    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    typedef logic [BUS_AW-1:0] bus_adr_t;
    typedef logic [BUS_DW-1:0] bus_dat_t;

    // Lane counter width; never below one bit, even for a single-lane word.
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/systemverilog_str2bus_bus_obuf.sv
// Single-entry bus write holding register: load on a completed word, retire on vld&rdy, address advances per retire.
// Zero added latency; the caller may load only when the entry is empty or retiring this cycle (STR2BUS_FLUSH_EN adds ben).
module systemverilog_bus_obuf
    import systemverilog_str2bus_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW,
`ifdef STR2BUS_FLUSH_EN
    parameter int BPW = BUS_DW / STR_BW,
`endif
    parameter logic [AW-1:0] ADR_BASE = '0,
    parameter logic [AW-1:0] ADR_INC  = AW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_dat,
`ifdef STR2BUS_FLUSH_EN
    input  logic [BPW-1:0] load_ben,
    output logic [BPW-1:0] ben,
`endif
    input  logic          rdy,
    output logic          vld,
    output logic [AW-1:0] adr,
    output logic [DW-1:0] dat
);

    logic retire;

    assign retire = vld && rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            adr <= ADR_BASE;
            dat <= '0;
`ifdef STR2BUS_FLUSH_EN
            ben <= '0;
`endif
        end else begin
            // Address wraps modulo 2**AW through natural overflow.
            if (retire) begin
                adr <= adr + ADR_INC;
            end
            if (load) begin
                vld <= 1'b1;
                dat <= load_dat;
`ifdef STR2BUS_FLUSH_EN
                ben <= load_ben;
`endif
            end else if (retire) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/systemverilog_str2bus.sv
// Packs BW-bit stream bytes little-endian into DW-bit words and writes them at incrementing addresses; word out 1 clk after last byte.
// Stalls only the last byte of a word while the output register is held; STR2BUS_FLUSH_EN adds flush/bso_ben for partial words.
module systemverilog_str2bus
    import systemverilog_str2bus_pkg::*;
#(
    parameter int BW = STR_BW,
    parameter int DW = BUS_DW,
    parameter int AW = BUS_AW,
    parameter logic [AW-1:0] ADR_BASE = '0,
    parameter logic [AW-1:0] ADR_INC  = AW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          str_vld,
    input  logic [BW-1:0] str_bus,
    output logic          str_rdy,
    output logic          bso_vld,
    output logic [AW-1:0] bso_adr,
    output logic [DW-1:0] bso_dat,
`ifdef STR2BUS_FLUSH_EN
    input  logic          flush,
    output logic [DW/BW-1:0] bso_ben,
`endif
    input  logic          bso_rdy
);

    localparam int BPW = DW / BW;
    localparam int CW  = cnt_width(BPW);

    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  part_cnt;
    logic [DW-1:0]  shreg;
    logic [DW-1:0]  word_nxt;
    logic           rdy_q;
    logic           str_trn;
    logic           last_lane;
    logic           obuf_free;
    logic           full_load;
    logic           obuf_load;

    assign obuf_free = !bso_vld || bso_rdy;
    assign last_lane = (cnt == CW'(BPW - 1));
    assign str_trn   = str_vld && str_rdy;
    assign cnt_inc   = last_lane ? '0 : cnt + 1'b1;
    // Fill level after this cycle's byte; zero when the byte completes a word.
    assign part_cnt  = str_trn ? cnt_inc : cnt;
    assign full_load = str_trn && last_lane;

    always_comb begin
        word_nxt = shreg;
        if (str_trn) begin
            word_nxt[cnt*BW +: BW] = str_bus;
        end
    end

`ifdef STR2BUS_FLUSH_EN
    logic           flush_pend;
    logic           flush_req;
    logic           part_has;
    logic           flush_load;
    logic [BPW-1:0] load_ben;

    assign flush_req  = flush || flush_pend;
    assign part_has   = (part_cnt != '0);
    assign flush_load = flush_req && part_has && obuf_free;
    assign obuf_load  = full_load || flush_load;
    assign load_ben   = full_load ? '1 : ((BPW'(1) << part_cnt) - BPW'(1));
    // A waiting flush freezes the stream so the partial word stays intact.
    assign str_rdy    = rdy_q && !flush_pend && !(last_lane && !obuf_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= flush_req && part_has && !obuf_free;
        end
    end
`else
    assign obuf_load = full_load;
    assign str_rdy   = rdy_q && !(last_lane && !obuf_free);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (obuf_load) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (str_trn) begin
                cnt   <= cnt_inc;
                shreg <= word_nxt;
            end
        end
    end

    systemverilog_bus_obuf #(
        .AW       (AW),
        .DW       (DW),
`ifdef STR2BUS_FLUSH_EN
        .BPW      (BPW),
`endif
        .ADR_BASE (ADR_BASE),
        .ADR_INC  (ADR_INC)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (obuf_load),
        .load_dat (word_nxt),
`ifdef STR2BUS_FLUSH_EN
        .load_ben (load_ben),
        .ben      (bso_ben),
`endif
        .rdy      (bso_rdy),
        .vld      (bso_vld),
        .adr      (bso_adr),
        .dat      (bso_dat)
    );

endmodule

// File: tb/tb_systemverilog_str2bus.sv
// Bench for systemverilog_str2bus: a base-0 instance plus a base-FFFF_FFFF instance for address wrap.
// Flush cases run only when STR2BUS_FLUSH_EN is defined.
module tb_systemverilog_str2bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        str_vld = 1'b0;
    logic [7:0]  str_bus = 8'hEE;
    logic        bso_rdy = 1'b1;
    logic        str_rdy, bso_vld, w_str_rdy, w_vld;
    logic [31:0] bso_adr, bso_dat, w_adr, w_dat;
`ifdef STR2BUS_FLUSH_EN
    logic        flush = 1'b0;
    logic [3:0]  bso_ben, w_ben;
    logic [3:0]  q_ben[$];
`endif

    logic [31:0] q_adr[$], q_dat[$], qw_adr[$];
    int          errors = 0;
    int          checks = 0;
    int          stalls = 0;
    logic        rnd_done = 1'b0;

    always #5 clk = ~clk;

    systemverilog_str2bus dut (
        .clk(clk), .rst_n(rst_n), .str_vld(str_vld), .str_bus(str_bus), .str_rdy(str_rdy),
        .bso_vld(bso_vld), .bso_adr(bso_adr), .bso_dat(bso_dat),
`ifdef STR2BUS_FLUSH_EN
        .flush(flush), .bso_ben(bso_ben),
`endif
        .bso_rdy(bso_rdy)
    );

    systemverilog_str2bus #(.ADR_BASE(32'hFFFF_FFFF)) dut_w (
        .clk(clk), .rst_n(rst_n), .str_vld(str_vld), .str_bus(str_bus), .str_rdy(w_str_rdy),
        .bso_vld(w_vld), .bso_adr(w_adr), .bso_dat(w_dat),
`ifdef STR2BUS_FLUSH_EN
        .flush(flush), .bso_ben(w_ben),
`endif
        .bso_rdy(bso_rdy)
    );

    // Inputs change only just after posedge, so a negedge sample sees the next edge's handshake.
    always @(negedge clk) begin
        if (rst_n && bso_vld && bso_rdy) begin
            q_adr.push_back(bso_adr);
            q_dat.push_back(bso_dat);
`ifdef STR2BUS_FLUSH_EN
            q_ben.push_back(bso_ben);
`endif
        end
        if (rst_n && w_vld && bso_rdy) begin
            qw_adr.push_back(w_adr);
        end
    end

    typedef struct {
        logic [0:3][7:0] b;
        logic [31:0]     word;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        q_adr.delete();
        q_dat.delete();
        qw_adr.delete();
`ifdef STR2BUS_FLUSH_EN
        q_ben.delete();
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        str_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bso_rdy = 1'b1;
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic ok;
        n       = 0;
        ok      = 1'b0;
        str_vld = 1'b1;
        str_bus = b;
        while (!ok && n <= 200) begin
            @(negedge clk);
            if (str_rdy) ok = 1'b1;
            else begin
                if (n == 0) stalls++;
                n++;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
        str_vld = 1'b0;
        str_bus = 8'hEE;
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (q_dat.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("write_count", q_dat.size(), n);
    endtask

    vec_t        vecs[4];
    logic [7:0]  rbytes[$];
    logic [31:0] exp_w;

    initial begin
        vecs[0] = '{b: {8'h01, 8'h02, 8'h03, 8'h04}, word: 32'h04030201};
        vecs[1] = '{b: {8'h05, 8'h06, 8'h07, 8'h08}, word: 32'h08070605};
        vecs[2] = '{b: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, word: 32'hEFBEADDE};
        vecs[3] = '{b: {8'h00, 8'hFF, 8'h80, 8'h7F}, word: 32'h7F80FF00};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_str_rdy", str_rdy, 0);
        check("rst_bso_vld", bso_vld, 0);
        check("rst_bso_adr", bso_adr, 0);
        check("rst_bso_dat", bso_dat, 0);
        check("rst_wrap_adr", w_adr, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rdy_before_edge", str_rdy, 0);
        @(posedge clk);
        #1 check("rdy_after_edge", str_rdy, 1);

        // Reset mid-word with a pending output discards both
        bso_rdy = 1'b0;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        check("pend_vld", bso_vld, 1);
        send_byte(8'hA1); send_byte(8'hA2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_vld", bso_vld, 0);
        check("midrst_adr", bso_adr, 0);
        check("midrst_dat", bso_dat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bso_rdy = 1'b1;
        clear_logs();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_writes(1);
        if (q_dat.size() >= 1) begin
            check("t1_dat", q_dat[0], 32'h44332211);
            check("t1_adr", q_adr[0], 0);
        end

        // Back-to-back streaming from the vector table
        do_reset();
        stalls = 0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                send_byte(vecs[i].b[k]);
        wait_writes(4);
        for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
            check($sformatf("vec%0d_dat", i), q_dat[i], vecs[i].word);
            check($sformatf("vec%0d_adr", i), q_adr[i], i);
        end
        check("stream_stalls", stalls, 0);
        check("wrap_count", qw_adr.size(), 4);
        if (qw_adr.size() >= 2) begin
            check("wrap_adr0", qw_adr[0], 32'hFFFF_FFFF);
            check("wrap_adr1", qw_adr[1], 32'h0000_0000);
        end

        // Back-pressure: last byte of word 1 held while word 0 pending
        do_reset();
        bso_rdy = 1'b0;
        stalls  = 0;
        send_byte(8'h10); send_byte(8'h11); send_byte(8'h12); send_byte(8'h13);
        send_byte(8'h20); send_byte(8'h21); send_byte(8'h22);
        check("bp_early_stalls", stalls, 0);
        str_vld = 1'b1;
        str_bus = 8'h23;
        repeat (3) @(negedge clk);
        check("bp_rdy_low", str_rdy, 0);
        check("bp_vld", bso_vld, 1);
        check("bp_dat_stable", bso_dat, 32'h13121110);
        check("bp_adr", bso_adr, 0);
        @(posedge clk);
        #1 bso_rdy = 1'b1;
        #1 check("bp_rdy_comb", str_rdy, 1);
        send_byte(8'h23);
        check("swap_vld", bso_vld, 1);
        check("swap_adr", bso_adr, 1);
        check("swap_dat", bso_dat, 32'h23222120);
        wait_writes(2);
        if (q_dat.size() >= 2) begin
            check("bp_w0", q_dat[0], 32'h13121110);
            check("bp_w1", q_dat[1], 32'h23222120);
            check("bp_a1", q_adr[1], 1);
        end

        // Random valid/ready, 1000 bytes
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bso_rdy = rnd_done ? 1'b1 : 1'($urandom_range(0, 1));
                end
                bso_rdy = 1'b1;
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            rbytes.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_byte(rbytes[i]);
        end
        rnd_done = 1'b1;
        repeat (2) @(posedge clk);
        wait_writes(250);
        for (int w = 0; w < 250 && w < q_dat.size(); w++) begin
            exp_w = {rbytes[4*w+3], rbytes[4*w+2], rbytes[4*w+1], rbytes[4*w]};
            check($sformatf("rnd_dat%0d", w), q_dat[w], exp_w);
            check($sformatf("rnd_adr%0d", w), q_adr[w], w);
        end

`ifdef STR2BUS_FLUSH_EN
        // Partial-word flush, then an ignored flush at lane 0
        do_reset();
        send_byte(8'hAA); send_byte(8'hBB);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wait_writes(1);
        if (q_dat.size() >= 1) begin
            check("flush_dat", q_dat[0], 32'h0000BBAA);
            check("flush_ben", q_ben[0], 4'b0011);
            check("flush_adr", q_adr[0], 0);
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("flush_idle_nowrite", q_dat.size(), 1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_writes(2);
        if (q_dat.size() >= 2) begin
            check("full_ben", q_ben[1], 4'b1111);
            check("full_dat", q_dat[1], 32'h04030201);
            check("full_adr", q_adr[1], 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
